// File: rtl/sc_config_regbank_if.sv
// ---------------------------------------------------------------------------
// sc_config_regbank_if
//
// Avalon-MM slave bus used to reach the configuration register bank.
// Word addressed, 32-bit data, fixed one-cycle read latency, never stalls.
//
// Signals
//   address        word address (ADDR_W bits)
//   writedata      32-bit write data
//   byteenable     per-byte write enables, bit b covers writedata[8b+7:8b]
//   write          write strobe (qualified by chipselect)
//   read           read strobe (qualified by chipselect)
//   chipselect     slave select
//   readdata       registered read data, zero when not valid
//   readdatavalid  read data qualifier, one cycle after an accepted read
//   waitrequest_n  always 1, the slave never inserts wait states
//
// Modports
//   master  drives the strobes, samples read data
//   slave   samples the strobes, drives read data
// ---------------------------------------------------------------------------
interface sc_config_regbank_if #(
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] address;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic              write;
    logic              read;
    logic              chipselect;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              waitrequest_n;

    modport master (
        output address,
        output writedata,
        output byteenable,
        output write,
        output read,
        output chipselect,
        input  readdata,
        input  readdatavalid,
        input  waitrequest_n
    );

    modport slave (
        input  address,
        input  writedata,
        input  byteenable,
        input  write,
        input  read,
        input  chipselect,
        output readdata,
        output readdatavalid,
        output waitrequest_n
    );
endinterface

// File: rtl/sc_config_regbank.sv
// ---------------------------------------------------------------------------
// sc_config_regbank
//
// Register bank with read-only status words, double-buffered configuration
// words and a status-change interrupt, reached over an Avalon-MM slave.
//
// Software writes the shadow copy of the configuration, then requests a
// commit. The shadow copy is transferred to the active copy (config_o) in
// one go at the next frame boundary (commit_strobe_i), so downstream logic
// never sees a half-updated configuration. Setting IMMEDIATE makes the
// active copy follow the shadow copy every cycle.
//
// Word map (S = N_STATUS, C = N_STATUS + N_CONFIG)
//   0 .. S-1      status words (RO, live value of status_i)
//   S .. C-1      shadow configuration words (RW, byte enables honoured)
//   C             CTRL   bit0 COMMIT (W1, reads 0), bit1 IMMEDIATE (RW),
//                        bit2 PENDING (RO)
//   C+1           CHG    per status word change flags, write-1-to-clear
//   C+2           IRQ_EN per status word interrupt enables
//   others        read 0, writes ignored
//
// Ports
//   clk_i            single clock, rising edge
//   rst_i            asynchronous active-high reset
//   avalon_s         Avalon-MM slave (sc_config_regbank_if.slave)
//   status_i         N_STATUS packed 32-bit status words, word k at [32k+31:32k]
//   commit_strobe_i  frame-boundary pulse
//   config_o         N_CONFIG packed 32-bit active configuration words
//   commit_pending_o commit requested and not yet applied
//   irq_o            level interrupt, OR of enabled change flags (registered)
// ---------------------------------------------------------------------------
module sc_config_regbank #(
    parameter int N_STATUS = 3,
    parameter int N_CONFIG = 6,
    parameter int ADDR_W   = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    sc_config_regbank_if.slave       avalon_s,
    input  logic [N_STATUS*32-1:0]   status_i,
    input  logic                     commit_strobe_i,
    output logic [N_CONFIG*32-1:0]   config_o,
    output logic                     commit_pending_o,
    output logic                     irq_o
);

    localparam int S_BASE      = N_STATUS;
    localparam int CTRL_ADDR   = N_STATUS + N_CONFIG;
    localparam int CHG_ADDR    = CTRL_ADDR + 1;
    localparam int IRQ_EN_ADDR = CTRL_ADDR + 2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0]             shadow_reg [N_CONFIG];
    logic [31:0]             active_reg [N_CONFIG];
    logic                    immediate_reg;
    logic                    pending_reg;
    logic [N_STATUS-1:0]     chg_reg;
    logic [N_STATUS-1:0]     irq_en_reg;
    logic [N_STATUS*32-1:0]  prev_reg;
    logic                    prev_valid_reg;
    logic                    irq_reg;
    logic [31:0]             readdata_reg;
    logic                    readdatavalid_reg;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic                    wr_en;
    logic                    rd_en;
    logic [N_STATUS-1:0]     stat_sel;
    logic [N_CONFIG-1:0]     cfg_sel;
    logic                    ctrl_sel;
    logic                    chg_sel;
    logic                    irq_en_sel;
    logic [31:0]             byte_mask;

    assign wr_en      = avalon_s.chipselect & avalon_s.write;
    assign rd_en      = avalon_s.chipselect & avalon_s.read;
    assign ctrl_sel   = (avalon_s.address == ADDR_W'(CTRL_ADDR));
    assign chg_sel    = (avalon_s.address == ADDR_W'(CHG_ADDR));
    assign irq_en_sel = (avalon_s.address == ADDR_W'(IRQ_EN_ADDR));

    generate
        for (genvar gi = 0; gi < N_STATUS; gi++) begin : gen_stat_sel
            assign stat_sel[gi] = (avalon_s.address == ADDR_W'(gi));
        end
        for (genvar gi = 0; gi < N_CONFIG; gi++) begin : gen_cfg_sel
            assign cfg_sel[gi] = (avalon_s.address == ADDR_W'(S_BASE + gi));
        end
        for (genvar gi = 0; gi < 4; gi++) begin : gen_byte_mask
            assign byte_mask[8*gi +: 8] = {8{avalon_s.byteenable[gi]}};
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Commit control
    // -----------------------------------------------------------------------
    // A commit fires on a frame strobe only when a request is already
    // registered, so a COMMIT write landing on a strobe cycle waits for the
    // next strobe. IMMEDIATE bypasses the request and fires every cycle.
    logic commit_fire;
    logic commit_req;

    assign commit_fire = (pending_reg & commit_strobe_i) | immediate_reg;
    assign commit_req  = wr_en & ctrl_sel & avalon_s.byteenable[0]
                       & avalon_s.writedata[0];

    // -----------------------------------------------------------------------
    // Status change detection
    // -----------------------------------------------------------------------
    // prev_valid_reg masks the first compare after reset, when prev_reg
    // still holds the reset value rather than a real sample of status_i.
    logic [N_STATUS-1:0] status_change;
    logic [N_STATUS-1:0] chg_clr;
    logic [N_STATUS-1:0] chg_next;

    generate
        for (genvar gi = 0; gi < N_STATUS; gi++) begin : gen_status_change
            assign status_change[gi] = prev_valid_reg
                & (status_i[32*gi +: 32] != prev_reg[32*gi +: 32]);
        end
    endgenerate

    assign chg_clr  = (wr_en & chg_sel & avalon_s.byteenable[0])
                    ? avalon_s.writedata[N_STATUS-1:0] : '0;
    // A change detected in the clearing cycle must not be lost.
    assign chg_next = (chg_reg & ~chg_clr) | status_change;

    // -----------------------------------------------------------------------
    // Read mux (AND-OR over one-hot selects; unmapped addresses give 0)
    // -----------------------------------------------------------------------
    logic [31:0] rd_word;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_STATUS; i++) begin
            if (stat_sel[i]) begin
                rd_word = rd_word | status_i[32*i +: 32];
            end
        end
        for (int i = 0; i < N_CONFIG; i++) begin
            if (cfg_sel[i]) begin
                rd_word = rd_word | shadow_reg[i];
            end
        end
        if (ctrl_sel) begin
            rd_word = {29'd0, pending_reg, immediate_reg, 1'b0};
        end
        if (chg_sel) begin
            rd_word = {{(32-N_STATUS){1'b0}}, chg_reg};
        end
        if (irq_en_sel) begin
            rd_word = {{(32-N_STATUS){1'b0}}, irq_en_reg};
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CONFIG; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
            immediate_reg     <= 1'b0;
            pending_reg       <= 1'b0;
            chg_reg           <= '0;
            irq_en_reg        <= '0;
            prev_reg          <= '0;
            prev_valid_reg    <= 1'b0;
            irq_reg           <= 1'b0;
            readdata_reg      <= '0;
            readdatavalid_reg <= 1'b0;
        end else begin
            // Active takes the shadow value as it stood before any write in
            // the same cycle; the new write stays in shadow for the next
            // commit.
            for (int i = 0; i < N_CONFIG; i++) begin
                if (wr_en && cfg_sel[i]) begin
                    shadow_reg[i] <= (shadow_reg[i] & ~byte_mask)
                                   | (avalon_s.writedata & byte_mask);
                end
                if (commit_fire) begin
                    active_reg[i] <= shadow_reg[i];
                end
            end

            if (wr_en && ctrl_sel && avalon_s.byteenable[0]) begin
                immediate_reg <= avalon_s.writedata[1];
            end

            // A fresh request wins over the clear from a commit firing now.
            if (commit_req) begin
                pending_reg <= 1'b1;
            end else if (commit_fire) begin
                pending_reg <= 1'b0;
            end

            if (wr_en && irq_en_sel && avalon_s.byteenable[0]) begin
                irq_en_reg <= avalon_s.writedata[N_STATUS-1:0];
            end

            prev_reg       <= status_i;
            prev_valid_reg <= 1'b1;
            chg_reg        <= chg_next;
            irq_reg        <= |(chg_reg & irq_en_reg);

            readdatavalid_reg <= rd_en;
            readdata_reg      <= rd_en ? rd_word : '0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CONFIG; gi++) begin : gen_config_out
            assign config_o[32*gi +: 32] = active_reg[gi];
        end
    endgenerate

    assign commit_pending_o       = pending_reg;
    assign irq_o                  = irq_reg;
    assign avalon_s.readdata      = readdata_reg;
    assign avalon_s.readdatavalid = readdatavalid_reg;
    assign avalon_s.waitrequest_n = 1'b1;

endmodule
